data_router: RTL

- Consumes the single-cycle byte pulses produced by the input-pulse stage: byte, is-key flag and strobe.
- Key bytes are assembled into a KEY_BYTES-wide key register and handed to the keystream generator.
- Data bytes are buffered in a small show-ahead FIFO and offered to the cipher core over a valid/ready handshake.
- Raises busy so the interface FSM stops acknowledging host transfers before bytes would be lost.

---
 rtl/data_router.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/data_router.sv
// data_router: collects key bytes into a full-width key register and buffers
// data bytes in a small show-ahead FIFO for the cipher core.
// Optional build macro: DATA_ROUTER_STATS_EN adds accepted/dropped byte counters.
module data_router #(
  parameter int KEY_BYTES = 4,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_byte,
  input  logic                   in_is_key,
  input  logic                   in_pulse,
  output logic [8*KEY_BYTES-1:0] key_out,
  output logic                   key_valid,
  output logic                   key_load_pulse,
  output logic [7:0]             data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic                   busy,
  output logic                   err_nokey,
  output logic                   err_overflow,
  input  logic                   clear_err
`ifdef DATA_ROUTER_STATS_EN
  ,
  output logic [15:0]            bytes_accepted,
  output logic [15:0]            bytes_dropped
`endif
);

  localparam int KW     = 8 * KEY_BYTES;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int KCNT_W = $clog2(KEY_BYTES + 1);

  typedef enum logic [1:0] {
    KEY_EMPTY,
    KEY_LOADING,
    KEY_READY
  } key_state_t;

  key_state_t        key_state_reg;
  logic [KCNT_W-1:0] key_cnt_reg;
  logic [KW-1:0]     key_out_reg;
  logic              key_valid_reg;
  logic              key_load_pulse_reg;

  logic [7:0]        fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  fifo_cnt_reg;

  logic              err_nokey_reg;
  logic              err_overflow_reg;

  logic key_strobe;
  logic data_strobe;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;
  logic fifo_wr;
  logic drop_nokey;
  logic drop_ovf;

  assign key_strobe  = in_pulse && in_is_key;
  assign data_strobe = in_pulse && !in_is_key;
  assign fifo_full   = (fifo_cnt_reg == CNT_W'(DEPTH));
  assign fifo_empty  = (fifo_cnt_reg == '0);
  assign fifo_pop    = !fifo_empty && data_ready;
  // A full FIFO can still take a byte when the head leaves on the same edge.
  assign fifo_wr     = data_strobe && key_valid_reg && (!fifo_full || fifo_pop);
  assign drop_nokey  = data_strobe && !key_valid_reg;
  assign drop_ovf    = data_strobe && key_valid_reg && fifo_full && !fifo_pop;

  // Key assembly FSM: shift bytes in MSB-first, flag a complete key for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_state_reg      <= KEY_EMPTY;
      key_cnt_reg        <= '0;
      key_out_reg        <= '0;
      key_valid_reg      <= 1'b0;
      key_load_pulse_reg <= 1'b0;
    end else begin
      key_load_pulse_reg <= 1'b0;
      if (key_strobe) begin
        key_out_reg <= {key_out_reg[KW-9:0], in_byte};
        if (key_state_reg == KEY_READY) begin
          // New key started over a valid one: old key is invalid immediately.
          key_valid_reg <= 1'b0;
          key_cnt_reg   <= KCNT_W'(1);
          key_state_reg <= KEY_LOADING;
        end else if (key_cnt_reg == KCNT_W'(KEY_BYTES - 1)) begin
          key_valid_reg      <= 1'b1;
          key_load_pulse_reg <= 1'b1;
          key_cnt_reg        <= '0;
          key_state_reg      <= KEY_READY;
        end else begin
          key_cnt_reg   <= key_cnt_reg + KCNT_W'(1);
          key_state_reg <= KEY_LOADING;
        end
      end
    end
  end

  // FIFO storage; no reset so it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr_reg] <= in_byte;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({fifo_wr, fifo_pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  // Sticky error flags; a new error on the same edge beats clear_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_nokey_reg    <= 1'b0;
      err_overflow_reg <= 1'b0;
    end else begin
      if (drop_nokey) begin
        err_nokey_reg <= 1'b1;
      end else if (clear_err) begin
        err_nokey_reg <= 1'b0;
      end
      if (drop_ovf) begin
        err_overflow_reg <= 1'b1;
      end else if (clear_err) begin
        err_overflow_reg <= 1'b0;
      end
    end
  end

`ifdef DATA_ROUTER_STATS_EN
  logic [15:0] bytes_accepted_reg;
  logic [15:0] bytes_dropped_reg;

  // Saturating traffic counters, untouched by clear_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      bytes_accepted_reg <= '0;
      bytes_dropped_reg  <= '0;
    end else begin
      if (fifo_wr && bytes_accepted_reg != 16'hFFFF) begin
        bytes_accepted_reg <= bytes_accepted_reg + 16'd1;
      end
      if ((drop_nokey || drop_ovf) && bytes_dropped_reg != 16'hFFFF) begin
        bytes_dropped_reg <= bytes_dropped_reg + 16'd1;
      end
    end
  end

  assign bytes_accepted = bytes_accepted_reg;
  assign bytes_dropped  = bytes_dropped_reg;
`endif

  assign key_out        = key_out_reg;
  assign key_valid      = key_valid_reg;
  assign key_load_pulse = key_load_pulse_reg;
  // Show-ahead head; forced to zero while empty so stale entries never leak out.
  assign data_out       = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_reg];
  assign data_valid     = !fifo_empty;
  assign busy           = (fifo_cnt_reg >= CNT_W'(DEPTH - 1)) || (key_state_reg == KEY_LOADING);
  assign err_nokey      = err_nokey_reg;
  assign err_overflow   = err_overflow_reg;

endmodule
